// File: rtl/control_fsm.sv
// Multicycle CPU control unit: Moore FSM sequencing fetch/decode/execute with memory handshake stalls.
// Optional macro CONTROL_XOR_EN adds the R-type xor function (Funct 100110 -> ULAControl 111).
module control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       FlagZ,
  input  logic       MemReady,
  output logic [2:0] ULAControl,
  output logic       ULASrcA,
  output logic [1:0] ULASrcB,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t state_reg, state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  assign State = state_reg;

  always_comb begin
    state_next = FETCH;
    ULAControl = 3'b000;
    ULASrcA    = 1'b0;
    ULASrcB    = 2'b00;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    PCSrc      = 2'b00;
    PCEn       = 1'b0;

    case (state_reg)
      FETCH: begin
        ULASrcB    = 2'b01;
        IRWrite    = MemReady;
        PCEn       = MemReady;
        state_next = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ULASrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEXEC;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ULASrcA    = 1'b1;
        ULASrcB    = 2'b10;
        state_next = (Op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        IorD       = 1'b1;
        state_next = MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      // The write strobe stays up for the whole handshake, not just the completing cycle.
      MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        state_next = MemReady ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        ULASrcA = 1'b1;
        case (Funct)
          6'b100000: ULAControl = 3'b000;
          6'b100010: ULAControl = 3'b001;
          6'b100100: ULAControl = 3'b010;
          6'b100101: ULAControl = 3'b011;
          6'b101010: ULAControl = 3'b101;
`ifdef CONTROL_XOR_EN
          6'b100110: ULAControl = 3'b111;
`endif
          default:   ULAControl = 3'b000;
        endcase
        state_next = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ULASrcA    = 1'b1;
        ULAControl = 3'b001;
        PCSrc      = 2'b01;
        PCEn       = FlagZ;
      end
      ADDIEXEC: begin
        ULASrcA    = 1'b1;
        ULASrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: state_next = FETCH;
    endcase

    // Reset already forces FETCH; additionally suppress every architectural write.
    if (reset) begin
      IRWrite  = 1'b0;
      PCEn     = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized instruction-level bench for control_fsm: expected state traces and control words
// are built per instruction from the opcode, stall counts and flag values.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       FlagZ, MemReady;
  logic [2:0] ULAControl;
  logic       ULASrcA;
  logic [1:0] ULASrcB;
  logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [3:0] State;

  int tests = 0;
  int fails = 0;

  control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .FlagZ(FlagZ), .MemReady(MemReady),
    .ULAControl(ULAControl), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .IorD(IorD),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .PCSrc(PCSrc), .PCEn(PCEn), .State(State)
  );

  always #5 clk = ~clk;

  logic [14:0] dut_ctrl;
  assign dut_ctrl = {ULAControl, ULASrcA, ULASrcB, IorD, IRWrite, MemWrite,
                     RegWrite, RegDst, MemtoReg, PCSrc, PCEn};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    logic [2:0] r;
    r = 3'b000;
    if (f == 6'b100010) r = 3'b001;
    if (f == 6'b100100) r = 3'b010;
    if (f == 6'b100101) r = 3'b011;
    if (f == 6'b101010) r = 3'b101;
`ifdef CONTROL_XOR_EN
    if (f == 6'b100110) r = 3'b111;
`endif
    return r;
  endfunction

  // Expected control word from per-signal state-membership rules.
  function automatic logic [14:0] exp_ctrl(input int st, input bit mr, input bit fz,
                                           input logic [5:0] f, input bit rst);
    logic [2:0] alu;
    logic [1:0] srcb, pcsrc;
    bit srca, iord, irw, memw, regw, regdst, mtr, pcen;
    alu    = (st == 6) ? alu_of(f) : (st == 8) ? 3'b001 : 3'b000;
    srca   = st inside {2, 6, 8, 9};
    srcb   = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 : (st inside {2, 9}) ? 2'b10 : 2'b00;
    iord   = st inside {3, 5};
    irw    = (st == 0) && mr && !rst;
    memw   = (st == 5) && !rst;
    regw   = (st inside {4, 7, 10}) && !rst;
    regdst = (st == 7);
    mtr    = (st == 4);
    pcsrc  = (st == 8) ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
    pcen   = !rst && (((st == 0) && mr) || ((st == 8) && fz) || (st == 11));
    return {alu, srca, srcb, iord, irw, memw, regw, regdst, mtr, pcsrc, pcen};
  endfunction

  // Entered and left one time unit after a rising edge with the FSM in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input bit fz,
                           input int fw, input int mw);
    int seq[$];
    bit mrq[$];
    for (int i = 0; i < fw; i++) begin seq.push_back(0); mrq.push_back(1'b0); end
    seq.push_back(0); mrq.push_back(1'b1);
    seq.push_back(1); mrq.push_back(1'($urandom));
    case (op)
      6'b100011: begin
        seq.push_back(2); mrq.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin seq.push_back(3); mrq.push_back(1'b0); end
        seq.push_back(3); mrq.push_back(1'b1);
        seq.push_back(4); mrq.push_back(1'($urandom));
      end
      6'b101011: begin
        seq.push_back(2); mrq.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin seq.push_back(5); mrq.push_back(1'b0); end
        seq.push_back(5); mrq.push_back(1'b1);
      end
      6'b000000: begin
        seq.push_back(6); mrq.push_back(1'($urandom));
        seq.push_back(7); mrq.push_back(1'($urandom));
      end
      6'b000100: begin seq.push_back(8); mrq.push_back(1'($urandom)); end
      6'b001000: begin
        seq.push_back(9);  mrq.push_back(1'($urandom));
        seq.push_back(10); mrq.push_back(1'($urandom));
      end
      6'b000010: begin seq.push_back(11); mrq.push_back(1'($urandom)); end
      default: ;
    endcase
    Op = op; Funct = f; FlagZ = fz;
    foreach (seq[i]) begin
      MemReady = mrq[i];
      @(negedge clk);
      check($sformatf("state op=%b step%0d", op, i), 32'(State), 32'(seq[i]));
      check($sformatf("ctrl op=%b s%0d", op, seq[i]), 32'(dut_ctrl),
            32'(exp_ctrl(seq[i], mrq[i], fz, f, 1'b0)));
      @(posedge clk); #1;
    end
    $display("[TB] op=%b funct=%b fz=%0d fw=%0d mw=%0d cycles=%0d", op, f, fz, fw, mw, seq.size());
  endtask

  // Walks an lw/sw to its memory wait state, then asserts reset between clock edges.
  task automatic reset_mid_wait(input logic [5:0] op);
    int wait_st;
    wait_st = (op == 6'b100011) ? 3 : 5;
    Op = op; Funct = 6'($urandom); FlagZ = 1'b0; MemReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    MemReady = 1'b0;
    @(negedge clk);
    check("wait state", 32'(State), 32'(wait_st));
    #2 reset = 1'b1;
    #1;
    check("async rst state", 32'(State), 32'd0);
    check("async rst memwrite", 32'(MemWrite), 32'd0);
    check("async rst ctrl mr0", 32'(dut_ctrl), 32'(exp_ctrl(0, 1'b0, 1'b0, Funct, 1'b1)));
    MemReady = 1'b1;
    #1;
    check("rst ctrl mr1", 32'(dut_ctrl), 32'(exp_ctrl(0, 1'b1, 1'b0, Funct, 1'b1)));
    @(posedge clk); #1;
    check("rst held state", 32'(State), 32'd0);
    reset = 1'b0;
    $display("[TB] reset during state %0d", wait_st);
  endtask

  localparam logic [5:0] LEGAL_OPS [6] = '{6'b100011, 6'b101011, 6'b000000,
                                           6'b000100, 6'b001000, 6'b000010};
  localparam logic [5:0] R_FUNCTS [6] = '{6'b100000, 6'b100010, 6'b100100,
                                          6'b100101, 6'b101010, 6'b100110};

  initial begin
    reset = 1'b1; Op = '0; Funct = '0; FlagZ = 1'b0; MemReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", 32'(State), 32'd0);
    check("reset ctrl", 32'(dut_ctrl), 32'(exp_ctrl(0, 1'b0, 1'b0, 6'd0, 1'b1)));
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b100110, 1'b0, 0, 0);
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b101011, 6'b000000, 1'b0, 2, 2);
    reset_mid_wait(6'b101011);
    run_instr(6'b001000, 6'b000000, 1'b0, 1, 0);
    reset_mid_wait(6'b100011);
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, f;
      int k;
      k = int'($urandom_range(0, 6));
      if (k < 6) op = LEGAL_OPS[k];
      else begin
        op = 6'($urandom);
        if (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
          op = 6'b111111;
      end
      f = ($urandom_range(0, 3) != 0) ? R_FUNCTS[$urandom_range(0, 5)] : 6'($urandom);
      run_instr(op, f, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    check("final state", 32'(State), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 clk  in  1  rising-edge system clock.
REQ-002 reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-003 Op  in  6  instruction opcode field from instruction register.
REQ-004 Funct  in  6  R-type function field.
REQ-005 FlagZ  in  1  zero flag from ALU (1 = result zero).
REQ-006 MemReady  in  1  memory handshake; 1 = current read/write completes this cycle.
REQ-007 ULAControl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt, 111 xor.
REQ-008 ULASrcA  out  1  0 = PC, 1 = register A.
REQ-009 ULASrcB  out  2  00 = register B, 01 = constant 1, 10 = immediate, 11 = branch offset.
REQ-010 IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg  out  1 each  standard datapath strobes/selects.
REQ-011 PCSrc  out  2  00 = ALU result, 01 = ALU-out register, 10 = jump target.
REQ-012 PCEn  out  1  PC write enable.
REQ-013 State  out  4  current state code (debug).

Function
REQ-014 Moore FSM, state register updated on rising clk; outputs decoded from state (plus MemReady, FlagZ where stated); all unlisted outputs 0 in every state.
REQ-015 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11; codes 12-15 -> next state FETCH.
REQ-016 FETCH: IorD=0, ULASrcA=0, ULASrcB=01, ULAControl=000, PCSrc=00; IRWrite=PCEn=MemReady; stay while MemReady=0, else -> DECODE.
REQ-017 DECODE: ULASrcA=0, ULASrcB=11, add; next by Op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEXEC, 000010 -> JUMP, other -> FETCH.
REQ-018 MEMADR: ULASrcA=1, ULASrcB=10, add; Op 100011 -> MEMREAD, else -> MEMWRITE.
REQ-019 MEMREAD: IorD=1; stay while MemReady=0, else -> MEMWB.
REQ-020 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-021 MEMWRITE: IorD=1, MemWrite=1 held every cycle in state; stay while MemReady=0, else -> FETCH.
REQ-022 EXECUTE: ULASrcA=1, ULASrcB=00; Funct 100000->000, 100010->001, 100100->010, 100101->011, 101010->101, unlisted->000; -> ALUWB.
REQ-023 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-024 BRANCH: ULASrcA=1, ULASrcB=00, ULAControl=001, PCSrc=01, PCEn=FlagZ; -> FETCH.
REQ-025 ADDIEXEC: ULASrcA=1, ULASrcB=10, add; -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; -> FETCH.
REQ-026 JUMP: PCSrc=10, PCEn=1; -> FETCH.
REQ-027 Instruction latency (MemReady tied 1): R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3.

Reset
REQ-028 reset=1 sets state to FETCH immediately (asynchronous), regardless of current state, including mid-wait in MEMREAD/MEMWRITE.
REQ-029 While reset=1, IRWrite, PCEn, RegWrite, MemWrite forced 0; other outputs show FETCH values.
REQ-030 First rising clk after reset deasserts evaluates FETCH normally.

Configuration
REQ-031 Macro CONTROL_XOR_EN: defined -> EXECUTE maps Funct 100110 to ULAControl=111; undefined -> Funct 100110 maps to 000 (treated as unlisted).

Verification
REQ-032 Reset asserted in MEMWRITE with MemReady=0 -> State=0, MemWrite=0 same cycle, no clk needed.
REQ-033 MemReady=1, Op=000000, Funct=101010 -> States 0,1,6,7,0; ULAControl=101 in EXECUTE; RegWrite=1, RegDst=1 only in ALUWB.
REQ-034 Op=100011, MemReady low 3 cycles in MEMREAD -> State 3 held 4 cycles, IorD=1 throughout, then MEMWB with MemtoReg=1, RegWrite=1.
REQ-035 Op=000100 in BRANCH with FlagZ=1 -> PCEn=1, PCSrc=01, ULAControl=001; repeat with FlagZ=0 -> PCEn=0.
REQ-036 Op=000000, Funct=100110 -> ULAControl=111 with CONTROL_XOR_EN defined, 000 without.
REQ-037 Op=111111 -> States 0,1,0; no RegWrite, MemWrite, or PCEn after FETCH.
